// File: rtl/mipi_ctrl_pkg.sv
// MIPI CSI-2 receive link controller: shared types and defaults.
// State encoding, counter widths and the watchdog width helper.
package mipi_ctrl_pkg;

  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int EXP_LINES_DEF   = 720;
  localparam int LINE_W          = 12;
  localparam int ERR_W           = 8;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_WAIT_FS = 2'd2,
    S_STREAM  = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mipi_rx_ctrl_if.sv
// Control/status bundle between the lane front end and the link controller.
// The controller uses the slave view; the driving side uses master.
interface mipi_rx_ctrl_if;
  import mipi_ctrl_pkg::*;

  logic              enable;
  logic              word_vld;
  logic              pkt_done;
  logic              invalid_start;
  logic              fs_pulse;
  logic              re_find;
  logic              stream_en;
  logic              frame_start;
  logic              frame_end;
  logic              frame_err;
  logic [LINE_W-1:0] line_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [1:0]        state;

  modport slave (
    input  enable, word_vld, pkt_done,
    input  invalid_start, fs_pulse,
    output re_find, stream_en,
    output frame_start, frame_end, frame_err,
    output line_cnt, err_cnt, state
  );

  modport master (
    output enable, word_vld, pkt_done,
    output invalid_start, fs_pulse,
    input  re_find, stream_en,
    input  frame_start, frame_end, frame_err,
    input  line_cnt, err_cnt, state
  );

endinterface

// File: rtl/mipi_wdt.sv
// Link-loss watchdog: counts while running, expires every TIMEOUT_CYC
// cycles of silence and restarts itself on expiry.
module mipi_wdt
  import mipi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_exp
);

  localparam int W = cnt_w(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  // Expiry is a pure function of the count so the FSM may feed back
  // into i_clr without forming a combinational loop.
  assign o_exp = i_run && (r_cnt == LAST);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_run || o_exp) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mipi_rx_ctrl.sv
// MIPI receive link controller: sync hunt, frame tracking, line
// counting and error accounting. All outputs are registered.
module mipi_rx_ctrl
  import mipi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int EXP_LINES   = EXP_LINES_DEF
) (
  input  logic           sclk,
  input  logic           s_rst_n,
  mipi_rx_ctrl_if.slave  bus
);

  localparam logic [LINE_W-1:0] EXP_L = LINE_W'(EXP_LINES);
  localparam logic [LINE_W-1:0] EXP_M1 = LINE_W'(EXP_LINES - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_rf;
  logic              r_fs;
  logic              r_fe;
  logic              r_ferr;
  logic              r_se;
  logic [LINE_W-1:0] r_line;
  logic [ERR_W-1:0]  r_err;

  logic              w_rf;
  logic              w_fs;
  logic              w_fe;
  logic              w_ferr;
  logic              w_err_inc;
  logic [LINE_W-1:0] w_line;
  logic [LINE_W-1:0] w_lc;

  logic              w_exp;
  logic              w_tmo;
  logic              w_run;
  logic              w_clr;

  assign w_run = (r_state == S_HUNT) || (r_state == S_STREAM);
  assign w_clr = bus.word_vld || (w_nxt != r_state);
  assign w_tmo = w_exp && !bus.word_vld;

  mipi_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .i_clr   (w_clr),
    .i_run   (w_run),
    .o_exp   (w_exp)
  );

  always_comb begin
    w_nxt     = r_state;
    w_rf      = 1'b0;
    w_fs      = 1'b0;
    w_fe      = 1'b0;
    w_ferr    = 1'b0;
    w_err_inc = 1'b0;
    w_line    = r_line;
    w_lc      = r_line;
    if (!bus.enable) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_nxt = S_HUNT;
          w_rf  = 1'b1;
        end
        S_HUNT: begin
          if (bus.word_vld) begin
            w_nxt = S_WAIT_FS;
          end else if (w_tmo) begin
            w_rf = 1'b1;
          end
        end
        S_WAIT_FS: begin
          if (bus.fs_pulse) begin
            w_nxt  = S_STREAM;
            w_fs   = 1'b1;
            w_line = '0;
          end
        end
        S_STREAM: begin
          if (bus.invalid_start || w_tmo) begin
            w_nxt     = S_HUNT;
            w_rf      = 1'b1;
            w_err_inc = 1'b1;
          end else begin
            // Line end is folded into the old frame before any FS check.
            if (bus.pkt_done) begin
              if (r_line < EXP_L) begin
                w_lc = r_line + 1'b1;
                w_fe = (r_line == EXP_M1);
              end else begin
                w_ferr    = 1'b1;
                w_err_inc = 1'b1;
              end
            end
            w_line = w_lc;
            if (bus.fs_pulse) begin
              w_fs   = 1'b1;
              w_line = '0;
              if (w_lc != EXP_L) begin
                w_ferr    = 1'b1;
                w_err_inc = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= S_IDLE;
      r_rf    <= 1'b0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_ferr  <= 1'b0;
      r_se    <= 1'b0;
      r_line  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_nxt;
      r_rf    <= w_rf;
      r_fs    <= w_fs;
      r_fe    <= w_fe;
      r_ferr  <= w_ferr;
      r_se    <= (w_nxt == S_STREAM);
      r_line  <= w_line;
      if (w_err_inc && (r_err != ERR_MAX)) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign bus.re_find     = r_rf;
  assign bus.stream_en   = r_se;
  assign bus.frame_start = r_fs;
  assign bus.frame_end   = r_fe;
  assign bus.frame_err   = r_ferr;
  assign bus.line_cnt    = r_line;
  assign bus.err_cnt     = r_err;
  assign bus.state       = r_state;

endmodule
